// File: rtl/branch_target_buffer.sv
// Purpose: direct-mapped branch target buffer with per-entry saturating direction counters and perf counters.
// Latency: prediction registered one cycle after lookup; training updates take effect at the next edge.
// Backpressure: stall_i freezes the prediction register and drops the lookup; updates are never stalled.
module branch_target_buffer #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              lookup_valid_i,
    input  logic [31:0]       lookup_addr_i,
    output logic              predict_valid_o,
    output logic              predict_hit_o,
    output logic              predict_taken_o,
    output logic [31:0]       predict_target_o,
    input  logic              update_valid_i,
    input  logic [31:0]       update_addr_i,
    input  logic [31:0]       update_target_i,
    input  logic              update_taken_i,
    input  logic              update_jump_i,
    input  logic              update_mispredict_i,
    input  logic              flush_i,
    output logic [PERF_W-1:0] perf_update_o,
    output logic [PERF_W-1:0] perf_mispredict_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    // Newly allocated entries start weakly taken: only the MSB set.
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

    // Entry storage: valid bits are resettable flops, the rest is reset-free array storage.
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [31:0]        tgt_mem  [ENTRIES];
    logic               jump_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem  [ENTRIES];

    // Prediction pipeline register.
    logic        pv_q,    pv_d;
    logic        hit_q,   hit_d;
    logic        taken_q, taken_d;
    logic [31:0] ptgt_q,  ptgt_d;

    // Perf counters.
    logic [PERF_W-1:0] perf_upd_q, perf_upd_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    // Lookup side decode.
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_taken;
    logic [31:0]      l_target;

    // Update side decode and write controls.
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_bad_tgt;
    logic [CTR_W-1:0] u_ctr;
    logic [CTR_W-1:0] ctr_wdat;
    logic             tag_we;
    logic             tgt_we;
    logic             ctr_we;

    // Byte-offset bits of the instruction addresses carry no information for indexing.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{lookup_addr_i[1:0], update_addr_i[1:0]};

    assign l_idx = lookup_addr_i[IDX_W+1:2];
    assign l_tag = lookup_addr_i[31:IDX_W+2];
    assign u_idx = update_addr_i[IDX_W+1:2];
    assign u_tag = update_addr_i[31:IDX_W+2];

    // Lookup reads the pre-edge contents, which gives read-before-write against same-cycle updates and flushes.
    always_comb begin
        l_hit    = valid_q[l_idx] && (tag_mem[l_idx] == l_tag);
        l_taken  = l_hit && (jump_mem[l_idx] || ctr_mem[l_idx][CTR_W-1]);
        l_target = l_taken ? tgt_mem[l_idx] : (lookup_addr_i + 32'd4);
    end

    // Next prediction: hold everything on stall, otherwise capture this lookup (all zero when no lookup).
    always_comb begin
        pv_d    = pv_q;
        hit_d   = hit_q;
        taken_d = taken_q;
        ptgt_d  = ptgt_q;
        if (!stall_i) begin
            pv_d    = lookup_valid_i;
            hit_d   = lookup_valid_i && l_hit;
            taken_d = lookup_valid_i && l_taken;
            ptgt_d  = lookup_valid_i ? l_target : 32'd0;
        end
    end

    // Training decision: counter step on hit, allocate on taken miss, drop misaligned targets.
    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
        u_bad_tgt = update_taken_i && (update_target_i[1:0] != 2'b00);
        u_ctr     = ctr_mem[u_idx];
        valid_d   = valid_q;
        tag_we    = 1'b0;
        tgt_we    = 1'b0;
        ctr_we    = 1'b0;
        ctr_wdat  = u_ctr;
        if (flush_i) begin
            valid_d = '0;
        end else if (update_valid_i && reset_i) begin
            if (u_bad_tgt) begin
                if (u_hit) begin
                    valid_d[u_idx] = 1'b0;
                end
            end else if (u_hit) begin
                ctr_we = 1'b1;
                if (update_taken_i) begin
                    ctr_wdat = (u_ctr == CTR_MAX) ? u_ctr : u_ctr + CTR_W'(1);
                    tgt_we   = 1'b1;
                end else begin
                    ctr_wdat = (u_ctr == CTR_ZERO) ? u_ctr : u_ctr - CTR_W'(1);
                end
            end else if (update_taken_i) begin
                valid_d[u_idx] = 1'b1;
                tag_we         = 1'b1;
                tgt_we         = 1'b1;
                ctr_we         = 1'b1;
                ctr_wdat       = CTR_INIT;
            end
        end
    end

    // Perf counters count every resolution, flushed or not, and wrap naturally.
    always_comb begin
        perf_upd_d = perf_upd_q + PERF_W'(update_valid_i);
        perf_mis_d = perf_mis_q + PERF_W'(update_valid_i & update_mispredict_i);
    end

    // Resettable state: valid bits, prediction register and perf counters.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            valid_q    <= '0;
            pv_q       <= 1'b0;
            hit_q      <= 1'b0;
            taken_q    <= 1'b0;
            ptgt_q     <= 32'd0;
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pv_q       <= pv_d;
            hit_q      <= hit_d;
            taken_q    <= taken_d;
            ptgt_q     <= ptgt_d;
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    // Entry payload writes; contents are only meaningful behind a set valid bit.
    always_ff @(posedge clock_i) begin
        if (tag_we) begin
            tag_mem[u_idx] <= u_tag;
        end
        if (tgt_we) begin
            tgt_mem[u_idx]  <= update_target_i;
            jump_mem[u_idx] <= update_jump_i;
        end
        if (ctr_we) begin
            ctr_mem[u_idx] <= ctr_wdat;
        end
    end

    assign predict_valid_o   = pv_q;
    assign predict_hit_o     = hit_q;
    assign predict_taken_o   = taken_q;
    assign predict_target_o  = ptgt_q;
    assign perf_update_o     = perf_upd_q;
    assign perf_mispredict_o = perf_mis_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Purpose: self-checking bench for branch_target_buffer against a behavioural entry-table model.
// Latency: every cycle compares the registered prediction and perf counters after the edge.
// Backpressure: exercises stall_i holds, flush/update collisions and perf counter wrap.
module tb_branch_target_buffer;
    localparam int NENT  = 64;
    localparam int CMAX  = 3;
    localparam int CINIT = 2;

    logic        clock_i = 1'b0;
    logic        reset_i, stall_i, lookup_valid_i, update_valid_i;
    logic        update_taken_i, update_jump_i, update_mispredict_i, flush_i;
    logic [31:0] lookup_addr_i, update_addr_i, update_target_i;

    logic        predict_valid_o, predict_hit_o, predict_taken_o;
    logic [31:0] predict_target_o, perf_update_o, perf_mispredict_o;

    logic        p4_valid, p4_hit, p4_taken;
    logic [31:0] p4_target;
    logic [3:0]  p4_perf_upd, p4_perf_mis;

    always #5 clock_i = ~clock_i;

    branch_target_buffer dut (
        .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
        .predict_valid_o(predict_valid_o), .predict_hit_o(predict_hit_o),
        .predict_taken_o(predict_taken_o), .predict_target_o(predict_target_o),
        .update_valid_i(update_valid_i), .update_addr_i(update_addr_i),
        .update_target_i(update_target_i), .update_taken_i(update_taken_i),
        .update_jump_i(update_jump_i), .update_mispredict_i(update_mispredict_i),
        .flush_i(flush_i), .perf_update_o(perf_update_o), .perf_mispredict_o(perf_mispredict_o)
    );

    branch_target_buffer #(.ENTRIES(64), .CTR_W(2), .PERF_W(4)) dut4 (
        .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
        .predict_valid_o(p4_valid), .predict_hit_o(p4_hit),
        .predict_taken_o(p4_taken), .predict_target_o(p4_target),
        .update_valid_i(update_valid_i), .update_addr_i(update_addr_i),
        .update_target_i(update_target_i), .update_taken_i(update_taken_i),
        .update_jump_i(update_jump_i), .update_mispredict_i(update_mispredict_i),
        .flush_i(flush_i), .perf_update_o(p4_perf_upd), .perf_mispredict_o(p4_perf_mis)
    );

    // Reference model: table of entries plus the expected registered outputs.
    bit          m_vld [NENT];
    logic [31:0] m_addr[NENT];
    logic [31:0] m_tgt [NENT];
    bit          m_jmp [NENT];
    int          m_ctr [NENT];
    bit          e_pv, e_hit, e_tk;
    logic [31:0] e_tgt, e_pu, e_pm;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd4) % NENT);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i = idx_of(a);
        return m_vld[i] && ((m_addr[i] / 32'd256) == (a / 32'd256));
    endfunction

    // Advance the model over one clock edge from the currently driven inputs, then compare.
    task automatic tick();
        int  i;
        bit  hit;
        if (!reset_i) begin
            for (int k = 0; k < NENT; k++) m_vld[k] = 1'b0;
            e_pv = 0; e_hit = 0; e_tk = 0; e_tgt = 0; e_pu = 0; e_pm = 0;
        end else begin
            if (!stall_i) begin
                if (lookup_valid_i) begin
                    i     = idx_of(lookup_addr_i);
                    hit   = model_hit(lookup_addr_i);
                    e_pv  = 1;
                    e_hit = hit;
                    e_tk  = hit && (m_jmp[i] || m_ctr[i] >= CINIT);
                    e_tgt = e_tk ? m_tgt[i] : lookup_addr_i + 32'd4;
                end else begin
                    e_pv = 0; e_hit = 0; e_tk = 0; e_tgt = 0;
                end
            end
            if (update_valid_i) begin
                e_pu = e_pu + 1;
                if (update_mispredict_i) e_pm = e_pm + 1;
            end
            if (flush_i) begin
                for (int k = 0; k < NENT; k++) m_vld[k] = 1'b0;
            end else if (update_valid_i) begin
                i   = idx_of(update_addr_i);
                hit = model_hit(update_addr_i);
                if (update_taken_i && (update_target_i % 4) != 0) begin
                    if (hit) m_vld[i] = 1'b0;
                end else if (hit) begin
                    if (update_taken_i) begin
                        m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                        m_tgt[i] = update_target_i;
                        m_jmp[i] = update_jump_i;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (update_taken_i) begin
                    m_vld[i]  = 1'b1;
                    m_addr[i] = update_addr_i;
                    m_tgt[i]  = update_target_i;
                    m_jmp[i]  = update_jump_i;
                    m_ctr[i]  = CINIT;
                end
            end
        end
        @(posedge clock_i);
        #1;
        check("pv",       32'(predict_valid_o), 32'(e_pv));
        check("hit",      32'(predict_hit_o),   32'(e_hit));
        check("taken",    32'(predict_taken_o), 32'(e_tk));
        check("target",   predict_target_o,     e_tgt);
        check("perf_upd", perf_update_o,        e_pu);
        check("perf_mis", perf_mispredict_o,    e_pm);
        check("p4_tgt",   p4_target,            e_tgt);
        check("p4_upd",   32'(p4_perf_upd),     e_pu % 16);
        check("p4_mis",   32'(p4_perf_mis),     e_pm % 16);
    endtask

    task automatic idle();
        stall_i = 0; lookup_valid_i = 0; update_valid_i = 0; flush_i = 0;
        update_taken_i = 0; update_jump_i = 0; update_mispredict_i = 0;
    endtask

    task automatic do_upd(input logic [31:0] a, input logic [31:0] t, input bit tk, input bit jp, input bit mis);
        idle();
        update_valid_i = 1; update_addr_i = a; update_target_i = t;
        update_taken_i = tk; update_jump_i = jp; update_mispredict_i = mis;
        tick();
        idle();
    endtask

    task automatic do_look(input logic [31:0] a);
        idle();
        lookup_valid_i = 1; lookup_addr_i = a;
        tick();
        idle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 40) == 0) return 32'hFFFF_FFFC;
        a = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 2)) << 8);
        return a;
    endfunction

    logic [31:0] pu_before;

    initial begin
        reset_i = 0; lookup_addr_i = 0; update_addr_i = 0; update_target_i = 0;
        idle();
        tick();
        tick();
        reset_i = 1;

        // Cold lookup: miss, fall-through target.
        do_look(32'h100);
        check("t1_pv",  32'(predict_valid_o), 32'd1);
        check("t1_hit", 32'(predict_hit_o),   32'd0);
        check("t1_tgt", predict_target_o,     32'h104);

        // Allocate then predict taken; two not-taken steps drop below threshold.
        do_upd(32'h100, 32'h200, 1, 0, 0);
        do_look(32'h100);
        check("t2_hit", 32'(predict_hit_o),   32'd1);
        check("t2_tk",  32'(predict_taken_o), 32'd1);
        check("t2_tgt", predict_target_o,     32'h200);
        do_upd(32'h100, 32'h200, 0, 0, 1);
        do_upd(32'h100, 32'h200, 0, 0, 1);
        do_look(32'h100);
        check("t2b_tk",  32'(predict_taken_o), 32'd0);
        check("t2b_tgt", predict_target_o,     32'h104);

        // Saturation: 5 taken then 2 not-taken leaves counter at 1.
        for (int k = 0; k < 5; k++) do_upd(32'h100, 32'h200, 1, 0, 0);
        do_upd(32'h100, 32'h200, 0, 0, 0);
        do_upd(32'h100, 32'h200, 0, 0, 0);
        do_look(32'h100);
        check("t3_hit", 32'(predict_hit_o),   32'd1);
        check("t3_tk",  32'(predict_taken_o), 32'd0);

        // JAL stays taken regardless of counter.
        do_upd(32'h340, 32'h440, 1, 1, 0);
        for (int k = 0; k < 4; k++) do_upd(32'h340, 32'h444, 0, 0, 0);
        do_look(32'h340);
        check("t3_jal_tk",  32'(predict_taken_o), 32'd1);
        check("t3_jal_tgt", predict_target_o,     32'h440);

        // Aliasing on the same index with different tags.
        do_upd(32'h100, 32'h200, 1, 0, 0);
        do_look(32'h200);
        check("t4_alias_hit", 32'(predict_hit_o), 32'd0);
        do_upd(32'h200, 32'h500, 1, 0, 0);
        do_look(32'h100);
        check("t4_evict_hit", 32'(predict_hit_o), 32'd0);
        do_look(32'h200);
        check("t4_new_tgt", predict_target_o, 32'h500);

        // Same-cycle lookup and allocating update: read-before-write.
        idle(); flush_i = 1; tick(); idle();
        lookup_valid_i = 1; lookup_addr_i = 32'h100;
        update_valid_i = 1; update_addr_i = 32'h100; update_target_i = 32'h200; update_taken_i = 1;
        tick();
        idle();
        check("t5_rbw_hit", 32'(predict_hit_o), 32'd0);
        do_look(32'h100);
        check("t5_after_hit", 32'(predict_hit_o), 32'd1);

        // Flush wins over update, but the update is still counted.
        pu_before = e_pu;
        idle(); flush_i = 1;
        update_valid_i = 1; update_addr_i = 32'h600; update_target_i = 32'h700; update_taken_i = 1;
        tick();
        idle();
        check("t5_flush_cnt", perf_update_o, pu_before + 32'd1);
        do_look(32'h600);
        check("t5_flush_hit", 32'(predict_hit_o), 32'd0);

        // Stall freezes outputs while new lookups are presented.
        stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            lookup_valid_i = 1'(k % 2 == 0);
            lookup_addr_i  = 32'h900 + 32'(k * 4);
            tick();
            check("t6_stall_pv",  32'(predict_valid_o), 32'd1);
            check("t6_stall_tgt", predict_target_o,     32'h604);
        end
        idle();

        // Misaligned target: no allocation, and invalidates a hitting entry.
        do_upd(32'h700, 32'h202, 1, 0, 0);
        do_look(32'h700);
        check("t6_noalloc", 32'(predict_hit_o), 32'd0);
        do_upd(32'h700, 32'h800, 1, 0, 0);
        do_upd(32'h700, 32'h202, 1, 0, 0);
        do_look(32'h700);
        check("t6_inval", 32'(predict_hit_o), 32'd0);

        // Fall-through wraps at the top of the address space.
        do_look(32'hFFFF_FFFC);
        check("t6_wrap", predict_target_o, 32'h0);

        // Narrow perf counter wraps after 16.
        reset_i = 0; tick(); reset_i = 1;
        for (int k = 0; k < 17; k++) do_upd(32'h1000, 32'h0, 0, 0, 1);
        check("t6_p4_mis",  32'(p4_perf_mis),  32'd1);
        check("t6_p32_mis", perf_mispredict_o, 32'd17);

        // Randomized traffic checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            reset_i             = ($urandom_range(0, 299) != 0);
            stall_i             = ($urandom_range(0, 7) == 0);
            flush_i             = ($urandom_range(0, 59) == 0);
            lookup_valid_i      = ($urandom_range(0, 3) != 0);
            lookup_addr_i       = rand_addr();
            update_valid_i      = ($urandom_range(0, 1) == 1);
            update_addr_i       = rand_addr();
            update_target_i     = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFC);
            update_taken_i      = ($urandom_range(0, 2) != 0);
            update_jump_i       = ($urandom_range(0, 4) == 0);
            update_mispredict_i = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
